req_capture_enc: RTL

Captures edge-triggered requests on 8 lines into a sticky pending register and offers the highest-index pending, unmasked request as a 3-bit index over a valid/ready handshake. It sits directly upstream of the 8-to-3 priority encoder stage and absorbs its logic: raw request pulses in, one encoded index per accepted transfer out. Bit 7 has the highest priority (index 3'b111), bit 0 the lowest (index 3'b000).

---
 rtl/req_capture_enc_pkg.sv | 11 +
 rtl/req_capture_enc_prio_enc_n.sv | 22 ++
 rtl/req_capture_enc.sv | 101 ++++++++++
 3 files changed

// File: rtl/req_capture_enc_pkg.sv
// Shared definitions for the request capture / priority offer block.
package req_capture_enc_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int IDXW_DEF  = $clog2(WIDTH_DEF);

    // Offer FSM: IDLE waits for an eligible request, OFFER holds idx until accepted
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;
endpackage

// File: rtl/req_capture_enc_prio_enc_n.sv
// Combinational WIDTH-to-IDXW encoder: reports the highest set bit and whether any bit is set.
module prio_enc_n
    import req_capture_enc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_any
);

    // Scan upward so the last (highest) set bit wins
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_idx = IDXW'(i);
        end
        o_any = |i_vec;
    end

endmodule

// File: rtl/req_capture_enc.sv
// Edge-captured sticky request register feeding a non-preemptive priority offer
// over a valid/ready handshake. Bit WIDTH-1 has the highest priority.
module req_capture_enc
    import req_capture_enc_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_req,
    input  logic [WIDTH-1:0] i_mask,
    input  logic             i_ovf_clr,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_pending,
    output logic [WIDTH-1:0] o_ovf
);

    logic [WIDTH-1:0] r_req_q;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_ovf;
    logic [IDXW-1:0]  r_idx;
    logic             r_valid;
    state_t           r_state;

    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_elig;
    logic [IDXW-1:0]  w_enc_idx;
    logic             w_any;
    state_t           w_state_nxt;
    logic [IDXW-1:0]  w_idx_nxt;
    logic             w_valid_nxt;

    assign w_rise = i_req & ~r_req_q;
    // The accepted index retires its pending bit on the handshake edge
    assign w_clr  = (r_valid && i_ready) ? (WIDTH'(1) << r_idx) : '0;
    assign w_elig = r_pending & i_mask;

    prio_enc_n #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
        .i_vec (w_elig),
        .o_idx (w_enc_idx),
        .o_any (w_any)
    );

    // Edge detect, sticky pending (a new rise beats a same-cycle clear) and overflow flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_req_q   <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_req_q   <= i_req;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (i_ovf_clr) r_ovf <= '0;
            else           r_ovf <= r_ovf | (w_rise & r_pending & ~w_clr);
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: offer when anything is eligible, return to IDLE on acceptance
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)   w_state_nxt = S_OFFER;
            S_OFFER: if (i_ready) w_state_nxt = S_IDLE;
            default:              w_state_nxt = S_IDLE;
        endcase
    end

    // Output next values: idx is latched only on entry to OFFER, so no preemption
    always_comb begin
        w_valid_nxt = (w_state_nxt == S_OFFER);
        w_idx_nxt   = r_idx;
        if (r_state == S_IDLE && w_any) w_idx_nxt = w_enc_idx;
    end

    // Registered offer outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign o_idx     = r_idx;
    assign o_valid   = r_valid;
    assign o_pending = r_pending;
    assign o_ovf     = r_ovf;

endmodule
